sim_run_ctrl: RTL and testbench

//  Synthesizable run controller for the cpu top level. It is parametrised by channel count.
//  It watches per-channel halt/commit strobes and error sources, and runs a watchdog in absolute or idle mode.
//  It freezes saturating perf counters at end of run and reports a single done/status to the bench or debug port.

---
 rtl/sim_run_ctrl.sv | 136 +++++++++++++
 tb/tb_sim_run_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// Run controller: watches per-channel halt/commit strobes and error sources, runs a
// watchdog, and freezes saturating perf counters into a single done/status report.
module sim_run_ctrl #(
   parameter int NUM_CH       = 8,
   parameter int NUM_ERR      = 3,
   parameter int TIMEOUT      = 5000000,
   parameter int TO_MODE      = 0,
   parameter int DRAIN_CYCLES = 5,
   parameter int NUM_CNT      = 4,
   parameter int CNT_W        = 32
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [NUM_CH-1:0]                             halt,
   input  logic [NUM_CH-1:0]                             commit,
   input  logic [NUM_ERR-1:0]                            err,
   input  logic [NUM_CNT-1:0]                            cnt_inc,
   output logic                                          done,
   output logic [1:0]                                    status,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] halt_ch,
   output logic [NUM_ERR-1:0]                            err_src,
   output logic [CNT_W-1:0]                              cycles,
   output logic [NUM_CNT*CNT_W-1:0]                      cnt
);

   localparam int HCW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [1:0] ST_RUNNING = 2'd0;
   localparam logic [1:0] ST_HALT    = 2'd1;
   localparam logic [1:0] ST_ERROR   = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                   r_state;
   logic                     r_done;
   logic [1:0]               r_status;
   logic [HCW-1:0]           r_halt_ch;
   logic [NUM_ERR-1:0]       r_err_src;
   logic [CNT_W-1:0]         r_cycles;
   logic [NUM_CNT*CNT_W-1:0] r_cnt;
   logic [WD_W-1:0]          r_wdog;
   logic [DR_W-1:0]          r_drain;

   logic [HCW-1:0]           w_halt_idx;
   logic                     w_reload;
   logic [CNT_W-1:0]         w_cycles_nxt;
   logic [NUM_CNT*CNT_W-1:0] w_cnt_nxt;

   // Scanning from the top down leaves the lowest set halt bit as the winner.
   always_comb begin
      w_halt_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (halt[i]) w_halt_idx = HCW'(i);
      end
   end

   assign w_reload = (TO_MODE == 1) && (|commit);

   always_comb begin
      w_cycles_nxt = r_cycles;
      if (r_cycles != {CNT_W{1'b1}}) w_cycles_nxt = r_cycles + CNT_W'(1);
      w_cnt_nxt = r_cnt;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (cnt_inc[i] && (r_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
            w_cnt_nxt[i*CNT_W +: CNT_W] = r_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
   end

   // Counters only advance on RUN cycles that stay in RUN; the terminating cycle is not counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_RUN;
         r_done    <= 1'b0;
         r_status  <= ST_RUNNING;
         r_halt_ch <= '0;
         r_err_src <= '0;
         r_cycles  <= '0;
         r_cnt     <= '0;
         r_wdog    <= WD_W'(TIMEOUT);
         r_drain   <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (|err) begin
                  r_err_src <= err;
                  r_drain   <= DR_W'(DRAIN_CYCLES - 1);
                  r_state   <= S_DRAIN;
               end else if (|halt) begin
                  r_halt_ch <= w_halt_idx;
                  r_status  <= ST_HALT;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end else if (w_reload || (r_wdog != '0)) begin
                  r_wdog   <= w_reload ? WD_W'(TIMEOUT) : r_wdog - WD_W'(1);
                  r_cycles <= w_cycles_nxt;
                  r_cnt    <= w_cnt_nxt;
               end else begin
                  r_status <= ST_TIMEOUT;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DRAIN: begin
               if (r_drain == '0) begin
                  r_status <= ST_ERROR;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_drain <= r_drain - DR_W'(1);
               end
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign done    = r_done;
   assign status  = r_status;
   assign halt_ch = r_halt_ch;
   assign err_src = r_err_src;
   assign cycles  = r_cycles;
   assign cnt     = r_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: a vector table on a long-timeout instance plus
// hand-written sequences for watchdog, idle-reload, saturation and async reset.
module tb_sim_run_ctrl;

   logic         clk;
   logic         rst;
   logic [7:0]   halt;
   logic [7:0]   commit;
   logic [2:0]   err;
   logic [3:0]   cntInc;

   logic         aDone, bDone, cDone, dDone;
   logic [1:0]   aStatus, bStatus, cStatus, dStatus;
   logic [2:0]   aHaltCh, bHaltCh, cHaltCh, dHaltCh;
   logic [2:0]   aErrSrc, bErrSrc, cErrSrc, dErrSrc;
   logic [31:0]  aCycles, bCycles, cCycles;
   logic [127:0] aCnt, bCnt, cCnt;
   logic [3:0]   dCycles;
   logic [15:0]  dCnt;

   int errors = 0;
   int checks = 0;

   sim_run_ctrl #(.NUM_CH(8), .NUM_ERR(3), .TIMEOUT(1000), .TO_MODE(0),
                  .DRAIN_CYCLES(5), .NUM_CNT(4), .CNT_W(32)) dutA (
      .clk(clk), .rst(rst), .halt(halt), .commit(commit), .err(err), .cnt_inc(cntInc),
      .done(aDone), .status(aStatus), .halt_ch(aHaltCh), .err_src(aErrSrc),
      .cycles(aCycles), .cnt(aCnt));

   sim_run_ctrl #(.NUM_CH(8), .NUM_ERR(3), .TIMEOUT(16), .TO_MODE(0),
                  .DRAIN_CYCLES(5), .NUM_CNT(4), .CNT_W(32)) dutB (
      .clk(clk), .rst(rst), .halt(halt), .commit(commit), .err(err), .cnt_inc(cntInc),
      .done(bDone), .status(bStatus), .halt_ch(bHaltCh), .err_src(bErrSrc),
      .cycles(bCycles), .cnt(bCnt));

   sim_run_ctrl #(.NUM_CH(8), .NUM_ERR(3), .TIMEOUT(16), .TO_MODE(1),
                  .DRAIN_CYCLES(5), .NUM_CNT(4), .CNT_W(32)) dutC (
      .clk(clk), .rst(rst), .halt(halt), .commit(commit), .err(err), .cnt_inc(cntInc),
      .done(cDone), .status(cStatus), .halt_ch(cHaltCh), .err_src(cErrSrc),
      .cycles(cCycles), .cnt(cCnt));

   sim_run_ctrl #(.NUM_CH(8), .NUM_ERR(3), .TIMEOUT(1000), .TO_MODE(0),
                  .DRAIN_CYCLES(5), .NUM_CNT(4), .CNT_W(4)) dutD (
      .clk(clk), .rst(rst), .halt(halt), .commit(commit), .err(err), .cnt_inc(cntInc),
      .done(dDone), .status(dStatus), .halt_ch(dHaltCh), .err_src(dErrSrc),
      .cycles(dCycles), .cnt(dCnt));

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still reports.
   initial begin
      #200us;
      $display("[TB] FAIL timeLimit: got expired, want finished");
      $fatal(1, "[TB] time limit reached");
   end

   typedef struct {
      int           n;
      logic         rstn;
      logic [7:0]   halt;
      logic [2:0]   err;
      logic [3:0]   inc;
      logic         expDone;
      logic [1:0]   expStatus;
      logic [2:0]   expHaltCh;
      logic [2:0]   expErrSrc;
      logic [31:0]  expCycles;
      logic [127:0] expCnt;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [0:NV-1];

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      rst    = v.rstn;
      halt   = v.halt;
      err    = v.err;
      cntInc = v.inc;
      commit = 8'h00;
      repeat (v.n) step();
   endtask

   task automatic clearInputs();
      halt   = 8'h00;
      err    = 3'b000;
      cntInc = 4'h0;
      commit = 8'h00;
   endtask

   task automatic doReset();
      clearInputs();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      int n;
      bit earlyDone;

      rst = 1'b0;
      clearInputs();

      //            n    rst  halt   err     inc   done st    hc    es      cycles  cnt {c3,c2,c1,c0}
      vecs[0]  = '{1,   0, 8'h00, 3'b000, 4'h0, 0, 2'd0, 3'd0, 3'b000, 32'd0,  {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[1]  = '{10,  1, 8'h00, 3'b000, 4'h5, 0, 2'd0, 3'd0, 3'b000, 32'd10, {32'd0, 32'd10, 32'd0, 32'd10}};
      vecs[2]  = '{1,   1, 8'h24, 3'b000, 4'h5, 1, 2'd1, 3'd2, 3'b000, 32'd10, {32'd0, 32'd10, 32'd0, 32'd10}};
      vecs[3]  = '{100, 1, 8'h00, 3'b111, 4'hF, 1, 2'd1, 3'd2, 3'b000, 32'd10, {32'd0, 32'd10, 32'd0, 32'd10}};
      vecs[4]  = '{1,   0, 8'h00, 3'b000, 4'h0, 0, 2'd0, 3'd0, 3'b000, 32'd0,  {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[5]  = '{20,  1, 8'h00, 3'b000, 4'hA, 0, 2'd0, 3'd0, 3'b000, 32'd20, {32'd20, 32'd0, 32'd20, 32'd0}};
      vecs[6]  = '{1,   1, 8'h00, 3'b101, 4'hF, 0, 2'd0, 3'd0, 3'b101, 32'd20, {32'd20, 32'd0, 32'd20, 32'd0}};
      vecs[7]  = '{1,   1, 8'h00, 3'b000, 4'hF, 0, 2'd0, 3'd0, 3'b101, 32'd20, {32'd20, 32'd0, 32'd20, 32'd0}};
      vecs[8]  = '{1,   1, 8'h01, 3'b010, 4'hF, 0, 2'd0, 3'd0, 3'b101, 32'd20, {32'd20, 32'd0, 32'd20, 32'd0}};
      vecs[9]  = '{2,   1, 8'h00, 3'b000, 4'hF, 0, 2'd0, 3'd0, 3'b101, 32'd20, {32'd20, 32'd0, 32'd20, 32'd0}};
      vecs[10] = '{1,   1, 8'h00, 3'b000, 4'hF, 1, 2'd2, 3'd0, 3'b101, 32'd20, {32'd20, 32'd0, 32'd20, 32'd0}};
      vecs[11] = '{1,   1, 8'hFF, 3'b111, 4'hF, 1, 2'd2, 3'd0, 3'b101, 32'd20, {32'd20, 32'd0, 32'd20, 32'd0}};
      vecs[12] = '{1,   0, 8'h00, 3'b000, 4'h0, 0, 2'd0, 3'd0, 3'b000, 32'd0,  {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[13] = '{5,   1, 8'h00, 3'b000, 4'h1, 0, 2'd0, 3'd0, 3'b000, 32'd5,  {32'd0, 32'd0, 32'd0, 32'd5}};
      vecs[14] = '{1,   1, 8'hC0, 3'b000, 4'h1, 1, 2'd1, 3'd6, 3'b000, 32'd5,  {32'd0, 32'd0, 32'd0, 32'd5}};
      vecs[15] = '{1,   0, 8'h00, 3'b000, 4'h0, 0, 2'd0, 3'd0, 3'b000, 32'd0,  {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[16] = '{3,   1, 8'h00, 3'b000, 4'h0, 0, 2'd0, 3'd0, 3'b000, 32'd3,  {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[17] = '{1,   1, 8'h18, 3'b010, 4'h0, 0, 2'd0, 3'd0, 3'b010, 32'd3,  {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[18] = '{2,   1, 8'h00, 3'b000, 4'h0, 0, 2'd0, 3'd0, 3'b010, 32'd3,  {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[19] = '{3,   1, 8'h00, 3'b000, 4'h0, 1, 2'd2, 3'd0, 3'b010, 32'd3,  {32'd0, 32'd0, 32'd0, 32'd0}};

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d.done", i),    128'(aDone),   128'(vecs[i].expDone));
         checkOutput($sformatf("vec%0d.status", i),  128'(aStatus), 128'(vecs[i].expStatus));
         checkOutput($sformatf("vec%0d.halt_ch", i), 128'(aHaltCh), 128'(vecs[i].expHaltCh));
         checkOutput($sformatf("vec%0d.err_src", i), 128'(aErrSrc), 128'(vecs[i].expErrSrc));
         checkOutput($sformatf("vec%0d.cycles", i),  128'(aCycles), 128'(vecs[i].expCycles));
         checkOutput($sformatf("vec%0d.cnt", i),     aCnt,          vecs[i].expCnt);
      end

      // Absolute watchdog: quiet inputs, done must appear on the 17th edge after release.
      doReset();
      repeat (16) step();
      checkOutput("absTo.doneEarly", 128'(bDone), 128'(0));
      step();
      checkOutput("absTo.done", 128'(bDone), 128'(1));
      checkOutput("absTo.status", 128'(bStatus), 128'(3));
      checkOutput("absTo.cycles", 128'(bCycles), 128'(16));

      // Idle watchdog: commits every 10 cycles keep it alive, then it expires 17 edges after the last one.
      doReset();
      earlyDone = 1'b0;
      for (int k = 0; k < 200; k++) begin
         commit = ((k % 10) == 0) ? 8'h01 : 8'h00;
         step();
         if (cDone) earlyDone = 1'b1;
      end
      commit = 8'h00;
      checkOutput("idleTo.noTimeout", 128'(earlyDone), 128'(0));
      n = 9;
      while (!cDone && n < 40) begin
         step();
         n++;
      end
      checkOutput("idleTo.edgesAfterCommit", 128'(n), 128'(17));
      checkOutput("idleTo.status", 128'(cStatus), 128'(3));

      // Narrow counters saturate instead of wrapping.
      doReset();
      cntInc = 4'h1;
      repeat (40) step();
      halt = 8'h01;
      step();
      clearInputs();
      checkOutput("sat.done", 128'(dDone), 128'(1));
      checkOutput("sat.status", 128'(dStatus), 128'(1));
      checkOutput("sat.cnt", 128'(dCnt), 128'(16'h000F));
      checkOutput("sat.cycles", 128'(dCycles), 128'(4'hF));

      // Asynchronous reset in the middle of a drain clears everything without a clock edge.
      doReset();
      cntInc = 4'hF;
      repeat (3) step();
      halt = 8'h01;
      err  = 3'b001;
      step();
      clearInputs();
      repeat (2) step();
      checkOutput("midDrain.done", 128'(aDone), 128'(0));
      checkOutput("midDrain.status", 128'(aStatus), 128'(0));
      checkOutput("midDrain.errSrc", 128'(aErrSrc), 128'(3'b001));
      checkOutput("midDrain.cnt", aCnt, {32'd3, 32'd3, 32'd3, 32'd3});
      rst = 1'b0;
      #1;
      checkOutput("asyncRst.errSrc", 128'(aErrSrc), 128'(0));
      checkOutput("asyncRst.cnt", aCnt, 128'(0));
      checkOutput("asyncRst.cycles", 128'(aCycles), 128'(0));
      checkOutput("asyncRst.done", 128'(aDone), 128'(0));
      step();
      rst = 1'b1;
      repeat (6) step();
      checkOutput("afterRst.done", 128'(aDone), 128'(0));
      checkOutput("afterRst.cycles", 128'(aCycles), 128'(6));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
